// File: rtl/fall_pkg.sv
// Shared types and defaults for the fall-detection decision stage.
package fall_pkg;

  typedef enum logic [2:0] {
    MONITOR  = 3'd0,
    FREEFALL = 3'd1,
    IMPACT   = 3'd2,
    ALARM    = 3'd3
  } state_t;

  localparam logic [15:0] DEF_FREEFALL_MEAN_LO = 16'd400;
  localparam logic [15:0] DEF_IMPACT_STD_TH    = 16'd1500;
  localparam logic [15:0] DEF_STILL_STD_TH     = 16'd100;
  localparam int unsigned DEF_IMPACT_WINDOWS   = 2;
  localparam int unsigned DEF_CONFIRM_WINDOWS  = 3;
  localparam int unsigned DEF_TIMEOUT_WINDOWS  = 8;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int EV_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 q <= '0;
    else if (clr)              q <= '0;
    else if (inc && q != '1)   q <= q + W'(1);
  end

endmodule

// File: rtl/fall_classifier.sv
// Window-driven free-fall -> impact -> stillness recogniser with latched alarm.
module fall_classifier
  import fall_pkg::*;
#(
  parameter logic [15:0] FREEFALL_MEAN_LO = DEF_FREEFALL_MEAN_LO,
  parameter logic [15:0] IMPACT_STD_TH    = DEF_IMPACT_STD_TH,
  parameter logic [15:0] STILL_STD_TH     = DEF_STILL_STD_TH,
  parameter int unsigned IMPACT_WINDOWS   = DEF_IMPACT_WINDOWS,
  parameter int unsigned CONFIRM_WINDOWS  = DEF_CONFIRM_WINDOWS,
  parameter int unsigned TIMEOUT_WINDOWS  = DEF_TIMEOUT_WINDOWS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        feature_valid,
  input  logic [15:0] feature_mean,
  input  logic [15:0] feature_std,
  input  logic        alarm_ack,
  output logic        fall_detected,
  output logic        fall_alarm,
  output logic [2:0]  state_dbg,
  output logic [7:0]  event_count
);

  if (IMPACT_WINDOWS < 1 || IMPACT_WINDOWS > CNT_MAX) begin : g_bad_iw
    $error("IMPACT_WINDOWS must be in 1..15");
  end
  if (CONFIRM_WINDOWS < 1 || CONFIRM_WINDOWS > CNT_MAX) begin : g_bad_cw
    $error("CONFIRM_WINDOWS must be in 1..15");
  end
  if (TIMEOUT_WINDOWS < 1 || TIMEOUT_WINDOWS > CNT_MAX) begin : g_bad_tw
    $error("TIMEOUT_WINDOWS must be in 1..15");
  end

  state_t           state, state_next;
  logic             ff, imp, still;
  logic             win_clr, win_inc, still_clr, still_inc;
  logic [CNT_W-1:0] win_cnt, still_cnt;
  logic             confirm, ff_expire, timeout;
  logic             detect_d, alarm_d;

  assign ff    = feature_mean < FREEFALL_MEAN_LO;
  assign imp   = feature_std >= IMPACT_STD_TH;
  assign still = feature_std < STILL_STD_TH;

  // Counters increment by one, so "new value == N" is "current value == N-1".
  assign confirm   = feature_valid && state == IMPACT && still &&
                     still_cnt == CNT_W'(CONFIRM_WINDOWS - 1);
  assign timeout   = feature_valid && state == IMPACT &&
                     win_cnt == CNT_W'(TIMEOUT_WINDOWS - 1);
  assign ff_expire = feature_valid && state == FREEFALL && !imp &&
                     win_cnt == CNT_W'(IMPACT_WINDOWS - 1);

  always_comb begin
    win_clr   = 1'b0;
    win_inc   = 1'b0;
    still_clr = 1'b0;
    still_inc = 1'b0;
    unique case (state)
      MONITOR: if (feature_valid && ff) begin
        win_clr   = 1'b1;
        still_clr = 1'b1;
      end
      FREEFALL: if (feature_valid) begin
        if (imp) begin
          win_clr   = 1'b1;
          still_clr = 1'b1;
        end else begin
          win_inc = 1'b1;
        end
      end
      IMPACT: if (feature_valid) begin
        win_inc   = 1'b1;
        still_inc = still;
        still_clr = !still;
      end
      ALARM: if (alarm_ack) begin
        win_clr   = 1'b1;
        still_clr = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MONITOR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      MONITOR: if (feature_valid && ff) state_next = imp ? IMPACT : FREEFALL;
      FREEFALL: begin
        if (feature_valid && imp) state_next = IMPACT;
        else if (ff_expire)       state_next = MONITOR;
      end
      IMPACT: begin
        if (confirm)      state_next = ALARM;
        else if (timeout) state_next = MONITOR;
      end
      ALARM: if (alarm_ack) state_next = MONITOR;
      default: state_next = MONITOR;
    endcase
  end

  always_comb begin
    detect_d = confirm;
    alarm_d  = state_next == ALARM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fall_detected <= 1'b0;
      fall_alarm    <= 1'b0;
    end else begin
      fall_detected <= detect_d;
      fall_alarm    <= alarm_d;
    end
  end

  assign state_dbg = state;

  sat_counter #(.W(CNT_W)) u_win_cnt (
    .clk(clk), .reset(reset), .clr(win_clr), .inc(win_inc), .q(win_cnt)
  );

  sat_counter #(.W(CNT_W)) u_still_cnt (
    .clk(clk), .reset(reset), .clr(still_clr), .inc(still_inc), .q(still_cnt)
  );

  sat_counter #(.W(EV_W)) u_event_cnt (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(confirm), .q(event_count)
  );

endmodule
